// File: rtl/imem_pkg.sv
// Shared constants, fault codes and controller states for the instruction memory pipe.
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int          RSP_W    = 66;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_e;

  // Misalignment wins over range so a bad low address never looks like a valid word.
  function automatic logic [1:0] addr_fault(input logic [31:0] addr, input logic [29:0] depth);
    if (addr[1:0] != 2'b00)
      return FAULT_MISALIGN;
    else if (addr[31:2] >= depth)
      return FAULT_RANGE;
    else
      return FAULT_OK;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Response buffer: register-based FIFO with occupancy count and non-registered read port.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int WIDTH = RSP_W,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instrmem_pipe.sv
// Instruction memory with NOP fill after reset, program-load port and buffered fetch responses.
//   state   | meaning
//   ST_INIT | writing NOP_INSTR into word init_cnt, no fetches or program writes accepted
//   ST_RUN  | fill complete, fetch and program-load ports active
module instrmem_pipe
  import imem_pkg::*;
#(
  parameter int          MEM_DEPTH = 64,
  parameter int          RSP_DEPTH = 3,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic [1:0]  rsp_fault,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic        init_done
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [29:0]   DEPTH_W  = 30'(MEM_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(MEM_DEPTH - 1);

  imem_state_e   state_q, state_d;
  logic [AW-1:0] init_cnt;
  logic [31:0]   mem [MEM_DEPTH];

  logic          req_fire;
  logic [1:0]    req_fault;
  logic          prog_ok;
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  logic          s1_valid;
  logic [31:0]   s1_data;
  logic [31:0]   s1_addr;
  logic [1:0]    s1_fault;

  logic [RSP_W-1:0] fifo_rdata;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occupancy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT)
        init_cnt <= (init_cnt == LAST_IDX) ? '0 : init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_cnt == LAST_IDX)
      state_d = ST_RUN;
  end

  assign init_done = (state_q == ST_RUN);
  assign req_fault = addr_fault(req_addr, DEPTH_W);
  assign prog_ok   = init_done && prog_we && (addr_fault(prog_addr, DEPTH_W) == FAULT_OK);

  // Readiness only looks at registered occupancy, so rsp_ready never reaches req_ready.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
  assign req_ready = init_done && (occupancy < (CW+1)'(RSP_DEPTH));
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = NOP_INSTR;
    if (state_q == ST_INIT) begin
      mem_we   = 1'b1;
      mem_widx = init_cnt;
    end else if (prog_ok) begin
      mem_we    = 1'b1;
      mem_widx  = prog_addr[AW+1:2];
      mem_wdata = prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Separate read process gives read-first behaviour on a same-word collision.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      s1_data  <= (req_fault == FAULT_OK) ? mem[req_addr[AW+1:2]] : NOP_INSTR;
      s1_addr  <= req_addr;
      s1_fault <= req_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_valid <= 1'b0;
    else        s1_valid <= req_fire;
  end

  imem_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid),
    .wdata ({s1_fault, s1_addr, s1_data}),
    .pop   (rsp_ready),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_empty ? NOP_INSTR : fifo_rdata[31:0];
  assign rsp_addr  = fifo_empty ? 32'h0     : fifo_rdata[63:32];
  assign rsp_fault = fifo_empty ? FAULT_OK  : fifo_rdata[65:64];

endmodule

// File: tb/tb_instrmem_pipe.sv
// Self-checking bench for instrmem_pipe: reference-model scoreboard plus directed vectors.
module tb_instrmem_pipe;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] W_A  = 32'h00A0_0513;
  localparam logic [31:0] W_B  = 32'h0640_0593;
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data, rsp_addr;
  logic [1:0]  rsp_fault;
  logic        prog_we;
  logic [31:0] prog_addr, prog_data;
  logic        init_done;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  fault;
  } rsp_t;

  rsp_t        sb_q[$];
  logic [31:0] model_mem [64];
  logic        hold_prev = 1'b0;
  rsp_t        prev;

  instrmem_pipe #(.MEM_DEPTH(64), .RSP_DEPTH(3), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_fault(input logic [31:0] a);
    if (a[1:0] != 2'b00)      return 2'b01;
    if (a[31:2] >= 30'd64)    return 2'b10;
    return 2'b00;
  endfunction

  // Reference model and scoreboard, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      for (int i = 0; i < 64; i++) model_mem[i] = NOP;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'b0, rsp_valid}, 32'd1);
        check("hold_data", rsp_data, prev.data);
        check("hold_addr", rsp_addr, prev.addr);
      end
      hold_prev  = rsp_valid && !rsp_ready;
      prev.data  = rsp_data;
      prev.addr  = rsp_addr;
      prev.fault = rsp_fault;
      if (rsp_valid && rsp_ready) begin
        n_pop++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_rsp", rsp_addr, 32'hFFFF_FFFF);
        end else begin
          rsp_t e;
          e = sb_q.pop_front();
          check("sb_addr", rsp_addr, e.addr);
          check("sb_data", rsp_data, e.data);
          check("sb_fault", {30'b0, rsp_fault}, {30'b0, e.fault});
        end
      end else if (!rsp_valid) begin
        check("idle_outputs", rsp_data ^ rsp_addr ^ {30'b0, rsp_fault}, NOP);
      end
      if (req_valid && req_ready) begin
        rsp_t e;
        e.addr  = req_addr;
        e.fault = exp_fault(req_addr);
        e.data  = (e.fault == 2'b00) ? model_mem[req_addr[7:2]] : NOP;
        sb_q.push_back(e);
      end
      if (init_done && prog_we && exp_fault(prog_addr) == 2'b00)
        model_mem[prog_addr[7:2]] = prog_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int cyc = 0;
    prog_we = 1'b1; prog_addr = 32'h0; prog_data = BAD;
    while (!init_done && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 4) prog_we = 1'b0;
      if (cyc == 10) check("init_req_ready", {31'b0, req_ready}, 32'd0);
    end
    prog_we = 1'b0;
    check("init_cycles", cyc, 32'd64);
  endtask

  task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    int   n = 0;
    logic acc = 1'b0;
    req_valid = 1'b1; req_addr = a;
    while (!acc && n < 50) begin
      acc = req_ready;
      tick();
      n++;
    end
    req_valid = 1'b0;
    check("req_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic [31:0] a, output logic [1:0] f);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("rsp_arrives", {31'b0, rsp_valid}, 32'd1);
    d = rsp_data; a = rsp_addr; f = rsp_fault;
    tick();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  fault;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    logic [31:0] d, a;
    logic [1:0]  f;
    int          n_acc;
    int          pops0;

    vecs[0] = '{32'h0000_0000, W_A, 2'b00};
    vecs[1] = '{32'h0000_0004, W_B, 2'b00};
    vecs[2] = '{32'h0000_0002, NOP, 2'b01};
    vecs[3] = '{32'h0000_0100, NOP, 2'b10};
    vecs[4] = '{32'h0000_0103, NOP, 2'b01};
    vecs[5] = '{32'h0000_00FC, NOP, 2'b00};
    vecs[6] = '{32'hFFFF_FFFC, NOP, 2'b10};
    vecs[7] = '{32'h0000_0008, NOP, 2'b00};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (3) tick();
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_rsp_data", rsp_data, NOP);
    check("rst_rsp_addr", rsp_addr, 32'h0);
    check("rst_rsp_fault", {30'b0, rsp_fault}, 32'd0);

    rst_n = 1'b1;
    wait_init();
    rsp_ready = 1'b1;
    fetch(32'h0000_0040);
    get_rsp(d, a, f);
    check("fill_data", d, NOP);
    check("fill_fault", {30'b0, f}, 32'd0);
    fetch(32'h0000_0000);
    get_rsp(d, a, f);
    check("init_prog_ignored", d, NOP);

    prog_write(32'h0, W_A);
    prog_write(32'h4, W_B);
    prog_write(32'h100, BAD);
    prog_write(32'h1, BAD);

    // Back-to-back fetch: one-cycle latency, then one response per cycle.
    req_valid = 1'b1; req_addr = 32'h0;
    check("b2b_ready0", {31'b0, req_ready}, 32'd1);
    tick();
    check("b2b_latency", {31'b0, rsp_valid}, 32'd0);
    req_addr = 32'h4;
    check("b2b_ready1", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("b2b_valid0", {31'b0, rsp_valid}, 32'd1);
    check("b2b_data0", rsp_data, W_A);
    tick();
    check("b2b_valid1", {31'b0, rsp_valid}, 32'd1);
    check("b2b_data1", rsp_data, W_B);
    tick();
    check("b2b_empty", {31'b0, rsp_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].addr);
      get_rsp(d, a, f);
      check("vec_data", d, vecs[i].data);
      check("vec_addr", a, vecs[i].addr);
      check("vec_fault", {30'b0, f}, {30'b0, vecs[i].fault});
    end

    // Same-cycle write and fetch of word 5.
    prog_write(32'h14, 32'hAAAA_5555);
    prog_we = 1'b1; prog_addr = 32'h14; prog_data = 32'h1234_5678;
    req_valid = 1'b1; req_addr = 32'h14;
    check("coll_ready", {31'b0, req_ready}, 32'd1);
    tick();
    prog_we = 1'b0; req_valid = 1'b0;
    get_rsp(d, a, f);
    check("coll_old", d, 32'hAAAA_5555);
    fetch(32'h14);
    get_rsp(d, a, f);
    check("coll_new", d, 32'h1234_5678);

    // Backpressure: only RSP_DEPTH requests may be buffered.
    prog_write(32'h8,  32'h2222_0000);
    prog_write(32'hC,  32'h2222_0001);
    prog_write(32'h10, 32'h2222_0002);
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8; n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      logic acc;
      acc = req_ready;
      tick();
      if (acc) begin
        n_acc++;
        req_addr = req_addr + 32'd4;
      end
    end
    check("bp_accepted", n_acc, 32'd3);
    check("bp_ready_low", {31'b0, req_ready}, 32'd0);
    check("bp_head_data", rsp_data, 32'h2222_0000);
    check("bp_head_addr", rsp_addr, 32'h8);
    req_valid = 1'b0;
    pops0 = n_pop;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      get_rsp(d, a, f);
      check("bp_drain_data", d, 32'h2222_0000 + k);
    end
    tick();
    check("bp_drain_count", n_pop - pops0, 32'd3);
    check("bp_drained", {31'b0, rsp_valid}, 32'd0);

    // Reset with two responses buffered.
    rsp_ready = 1'b0;
    fetch(32'h0);
    fetch(32'h4);
    tick();
    check("rr_buffered", {31'b0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_valid_now", {31'b0, rsp_valid}, 32'd0);
    check("rr_ready_now", {31'b0, req_ready}, 32'd0);
    check("rr_done_now", {31'b0, init_done}, 32'd0);
    tick();
    rst_n = 1'b1;
    wait_init();
    check("rr_no_stale", {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    fetch(32'h0);
    get_rsp(d, a, f);
    check("rr_word0_nop", d, NOP);
    fetch(32'h4);
    get_rsp(d, a, f);
    check("rr_word1_nop", d, NOP);

    tick();
    check("sb_left_over", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
